xpb_table_gen: RTL and testbench
================================

XPB_TABLE_GEN -- requirements
Module: xpb_table_gen

Interface
REQ-001 Parameter WIDTH, default 1024, is the operand and table entry width in bits.
REQ-002 Parameter IDX_BITS, default 5, is the chunk index width; the table holds NUM_ENTRIES = 2**IDX_BITS entries.
REQ-003 Port clk, input, 1 bit, is the single clock; all state is updated on its rising edge.
REQ-004 Port rst_n, input, 1 bit, is the reset: asynchronous assert, active-low.
REQ-005 Port start, input, 1 bit, requests a table build; sampled only in IDLE.
REQ-006 Port base, input, WIDTH bits, is the entry-1 value (2^k mod N); sampled on accepted start.
REQ-007 Port modulus, input, WIDTH bits, is N; sampled on accepted start.
REQ-008 Port busy, output, 1 bit, is high while a build is in progress.
REQ-009 Port done, output, 1 bit, is a one-cycle pulse when a build completes successfully.
REQ-010 Port err, output, 1 bit, is a sticky flag set when a build is rejected (base >= modulus).
REQ-011 Port table_valid, output, 1 bit, is high when the table holds a complete build.
REQ-012 Port rd_addr, input, IDX_BITS bits, is the lookup chunk index.
REQ-013 Port rd_data, output, WIDTH bits, is the registered table entry selected by rd_addr.

Function
REQ-014 Entry j SHALL equal (j * base) mod modulus, for j = 0..NUM_ENTRIES-1.
REQ-015 The FSM SHALL have states IDLE, ADD, RED and DONE.
REQ-016 In IDLE, a start with base < modulus SHALL latch base and modulus, write entry 0 = 0, clear acc, set idx = 1, clear err, drop table_valid and go to ADD.
REQ-017 In IDLE, a start with base >= modulus SHALL set err, clear table_valid and stay in IDLE; no table entry changes.
REQ-018 ADD SHALL register sum = acc + base at WIDTH+1 bits, so no carry is lost, and go to RED.
REQ-019 RED SHALL compute diff = sum - modulus at WIDTH+1 bits.
REQ-020 RED SHALL set acc = diff if diff is non-negative, else acc = sum.
REQ-021 RED SHALL write acc into entry idx, then increment idx.
REQ-022 RED SHALL go to DONE when idx = NUM_ENTRIES-1, else back to ADD.
REQ-023 DONE SHALL assert done for exactly one cycle, set table_valid and return to IDLE.
REQ-024 busy SHALL be high in ADD, RED and DONE.
REQ-025 From accepted start to the done pulse takes exactly 2*(NUM_ENTRIES-1)+1 cycles: 63 cycles at default parameters.
REQ-026 start SHALL be ignored while busy.
REQ-027 rd_data SHALL update one cycle after rd_addr and present the stored entry.
REQ-028 While table_valid is low, rd_data content is undefined and consumers SHALL NOT rely on it.
REQ-029 A read of entry idx in the same cycle that entry idx is written SHALL return the old value.

Reset
REQ-030 While rst_n is low: state = IDLE; busy, done, err and table_valid = 0; rd_data = 0; acc = 0; idx = 0.
REQ-031 Table storage SHALL NOT be reset; table_valid gates its use.
REQ-032 Reset asserted mid-build SHALL abort the build; table_valid stays low until a later build completes.

Structure
REQ-033 Package xpb_pkg SHALL hold WIDTH, IDX_BITS, NUM_ENTRIES and the FSM state enum.
REQ-034 Sub-module xpb_modadd SHALL implement one conditional-subtract modular add step (sum register, diff, select) and be instantiated once.

Verification
REQ-035 base=1, modulus=100: after done, reading entries 0..31 returns 0..31.
REQ-036 base=60, modulus=100: entry 2 = 20, entry 5 = 0, entry 7 = 20, entry 31 = 60; done occurs 63 cycles after start.
REQ-037 modulus=2^1024-1, base=2^1024-2: entry 2 = 2^1024-3 and entry 3 = 2^1024-4, which checks carry into bit WIDTH.
REQ-038 base=modulus=100 with start: err=1, busy stays 0, table_valid=0, no done pulse.
REQ-039 Start mid-build with different operands: ignored, and the first build's results are intact.
REQ-040 Reset pulse at cycle 30 of a build: all outputs read 0; a new build then completes normally in 63 cycles.

Source files
------------

// File: rtl/xpb_pkg.sv
// Shared sizing and FSM encoding for the XPB table generator.
package xpb_pkg;

    localparam int WIDTH       = 1024;
    localparam int IDX_BITS    = 5;
    localparam int NUM_ENTRIES = 2 ** IDX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        RED,
        DONE
    } state_t;

endpackage

// File: rtl/xpb_table_gen_if.sv
// Control, operand and lookup signals of the XPB table generator.
interface xpb_table_gen_if #(
    parameter int WIDTH    = xpb_pkg::WIDTH,
    parameter int IDX_BITS = xpb_pkg::IDX_BITS
) ();

    logic                start;
    logic [WIDTH-1:0]    base;
    logic [WIDTH-1:0]    modulus;
    logic                busy;
    logic                done;
    logic                err;
    logic                table_valid;
    logic [IDX_BITS-1:0] rd_addr;
    logic [WIDTH-1:0]    rd_data;

    modport master (
        output start, base, modulus, rd_addr,
        input  busy, done, err, table_valid, rd_data
    );

    modport slave (
        input  start, base, modulus, rd_addr,
        output busy, done, err, table_valid, rd_data
    );

endinterface

// File: rtl/xpb_modadd.sv
// One modular add step: registers acc + base, then conditionally subtracts the modulus.
module xpb_modadd #(
    parameter int WIDTH = xpb_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH:0] sum_q, sum_d;
    logic [WIDTH:0] diff;

    always_comb begin
        sum_d  = load ? ({1'b0, acc} + {1'b0, base}) : sum_q;
        diff   = sum_q - {1'b0, modulus};
        // sum < 2*modulus, so diff[WIDTH] is set exactly when sum < modulus.
        result = diff[WIDTH] ? sum_q[WIDTH-1:0] : diff[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

endmodule

// File: rtl/xpb_table_gen.sv
// Builds the table entry[j] = (j * base) mod modulus by repeated modular addition
// and serves registered lookups from it.
module xpb_table_gen #(
    parameter int WIDTH    = xpb_pkg::WIDTH,
    parameter int IDX_BITS = xpb_pkg::IDX_BITS
) (
    input logic           clk,
    input logic           rst_n,
    xpb_table_gen_if.slave bus
);

    import xpb_pkg::*;

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(2 ** IDX_BITS - 1);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    base_q, base_d;
    logic [WIDTH-1:0]    mod_q, mod_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    rd_data_q, rd_data_d;

    logic                wr_en;
    logic [IDX_BITS-1:0] wr_addr;
    logic [WIDTH-1:0]    wr_data;
    logic                load_sum;
    logic [WIDTH-1:0]    next_acc;

    logic [WIDTH-1:0]    table_q [2 ** IDX_BITS];

    xpb_modadd #(.WIDTH(WIDTH)) u_modadd (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_sum),
        .acc     (acc_q),
        .base    (base_q),
        .modulus (mod_q),
        .result  (next_acc)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        base_d    = base_q;
        mod_d     = mod_q;
        idx_d     = idx_q;
        err_d     = err_q;
        valid_d   = valid_q;
        wr_en     = 1'b0;
        wr_addr   = idx_q;
        wr_data   = next_acc;
        load_sum  = 1'b0;
        rd_data_d = table_q[bus.rd_addr];

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    valid_d = 1'b0;
                    if (bus.base < bus.modulus) begin
                        base_d  = bus.base;
                        mod_d   = bus.modulus;
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        wr_data = '0;
                        acc_d   = '0;
                        idx_d   = IDX_BITS'(1);
                        err_d   = 1'b0;
                        state_d = ADD;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            ADD: begin
                load_sum = 1'b1;
                state_d  = RED;
            end
            RED: begin
                acc_d   = next_acc;
                wr_en   = 1'b1;
                idx_d   = idx_q + IDX_BITS'(1);
                state_d = (idx_q == LAST_IDX) ? DONE : ADD;
            end
            DONE: begin
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            base_q    <= '0;
            mod_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            base_q    <= base_d;
            mod_q     <= mod_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            rd_data_q <= rd_data_d;
        end
    end

    // NOTE: table storage is deliberately not reset; table_valid tells consumers when it is usable.
    always_ff @(posedge clk) begin
        if (wr_en) table_q[wr_addr] <= wr_data;
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.err         = err_q;
    assign bus.table_valid = valid_q;
    assign bus.rd_data     = rd_data_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench for xpb_table_gen: lookups are checked by a scoreboard monitor.
module tb_xpb_table_gen;

    localparam int W   = xpb_pkg::WIDTH;
    localparam int IB  = xpb_pkg::IDX_BITS;
    localparam int LAT = 2 * (xpb_pkg::NUM_ENTRIES - 1) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    xpb_table_gen_if #(.WIDTH(W), .IDX_BITS(IB)) bus ();

    xpb_table_gen #(.WIDTH(W), .IDX_BITS(IB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [W-1:0] exp;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    logic    rd_issue = 1'b0;
    logic    rd_pend  = 1'b0;
    int      n_checks = 0;
    int      n_pass   = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (low 64 bits)", name, got[63:0], exp[63:0]);
    endtask

    always @(posedge clk) rd_pend <= rd_issue;

    always @(negedge clk) begin : monitor
        rd_exp_t e;
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got data with no expected entry queued");
            end else begin
                e = exp_q.pop_front();
                check(e.name, bus.rd_data, e.exp);
            end
        end
    end

    task automatic rd(input string name, input int a, input logic [W-1:0] exp);
        rd_exp_t e;
        @(negedge clk);
        bus.rd_addr = IB'(a);
        rd_issue    = 1'b1;
        e.name      = name;
        e.exp       = exp;
        exp_q.push_back(e);
    endtask

    task automatic rd_flush();
        @(negedge clk);
        rd_issue = 1'b0;
        @(negedge clk);
        check("rd_drain", W'(exp_q.size()), '0);
    endtask

    task automatic run_build(input logic [W-1:0] b, input logic [W-1:0] m,
                             input int interfere_at, output int lat, output logic busy1);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.base    = b;
        bus.modulus = m;
        lat   = 0;
        busy1 = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0;
                busy1     = bus.busy;
            end
            if (c == interfere_at) begin
                bus.start   = 1'b1;
                bus.base    = W'(3);
                bus.modulus = W'(7);
            end
            if (c == interfere_at + 1) bus.start = 1'b0;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin : stim
        int           lat;
        int           hits;
        logic         busy1;
        logic [W-1:0] ones;
        ones        = '1;
        bus.start   = 1'b0;
        bus.base    = '0;
        bus.modulus = '0;
        bus.rd_addr = '0;

        #12;
        check("rst_busy",  W'(bus.busy),        '0);
        check("rst_done",  W'(bus.done),        '0);
        check("rst_err",   W'(bus.err),         '0);
        check("rst_valid", W'(bus.table_valid), '0);
        check("rst_rdata", bus.rd_data,         '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Identity table: entry j = j.
        run_build(W'(1), W'(100), 0, lat, busy1);
        check("b1_latency", W'(lat), W'(LAT));
        check("b1_busy",    W'(busy1), W'(1));
        @(negedge clk);
        check("b1_done_pulse", W'(bus.done),        '0);
        check("b1_valid",      W'(bus.table_valid), W'(1));
        for (int j = 0; j < 32; j++) rd($sformatf("b1_e%0d", j), j, W'(j));
        rd_flush();

        // base 60 mod 100, with an ignored start mid-build.
        run_build(W'(60), W'(100), 10, lat, busy1);
        check("b60_latency", W'(lat), W'(LAT));
        rd("b60_e1",  1,  W'(60));
        rd("b60_e2",  2,  W'(20));
        rd("b60_e3",  3,  W'(80));
        rd("b60_e5",  5,  W'(0));
        rd("b60_e7",  7,  W'(20));
        rd("b60_e31", 31, W'(60));
        rd_flush();

        // Near-full-width operands force a carry into bit WIDTH.
        run_build(ones - W'(1), ones, 0, lat, busy1);
        check("big_latency", W'(lat), W'(LAT));
        rd("big_e1",  1,  ones - W'(1));
        rd("big_e2",  2,  ones - W'(2));
        rd("big_e3",  3,  ones - W'(3));
        rd("big_e31", 31, ones - W'(31));
        rd_flush();

        // Rejected build: base == modulus.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.base    = W'(100);
        bus.modulus = W'(100);
        @(negedge clk);
        bus.start = 1'b0;
        check("rej_err",   W'(bus.err),         W'(1));
        check("rej_busy",  W'(bus.busy),        '0);
        check("rej_valid", W'(bus.table_valid), '0);
        hits = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) hits++;
        end
        check("rej_no_activity", W'(hits),    '0);
        check("rej_err_sticky",  W'(bus.err), W'(1));

        // Reset during a build, then a fresh build.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.base    = W'(7);
        bus.modulus = W'(13);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c == 2) check("abort_err_cleared", W'(bus.err), '0);
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy",  W'(bus.busy),        '0);
        check("abort_done",  W'(bus.done),        '0);
        check("abort_err",   W'(bus.err),         '0);
        check("abort_valid", W'(bus.table_valid), '0);
        check("abort_rdata", bus.rd_data,         '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_valid_after", W'(bus.table_valid), '0);
        run_build(W'(7), W'(13), 0, lat, busy1);
        check("b7_latency", W'(lat), W'(LAT));
        rd("b7_e2",  2,  W'(1));
        rd("b7_e5",  5,  W'(9));
        rd("b7_e13", 13, W'(0));
        rd("b7_e31", 31, W'(9));
        rd_flush();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
